// File: rtl/ifu_prefetch.sv
// Instruction prefetch: word-aligned fetch PC into a 1-cycle synchronous RAM, with
// a two-entry output/skid buffer toward decode, branch redirect with flush, and back-pressure.
module ifu_prefetch #(
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        MEM_AW    = 10,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0
) (
    input  logic              clk1,
    input  logic              pc_rst,
    input  logic              fetch_en,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] Inst_in,
    output logic [DATA_W-1:0] Inst_out,
    output logic [ADDR_W-1:0] PC_out,
    output logic              inst_valid,
    input  logic              dec_ready,
    output logic              align_err
);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_inst_q, out_inst_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_inst_q, skid_inst_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic              align_err_q, align_err_d;

    logic       pop;
    logic [1:0] occ;
    logic       issue;

    // occ counts words that will sit in the buffer after this edge, including the one in flight
    assign pop   = out_valid_q & dec_ready;
    assign occ   = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(inflight_q) - 2'(pop);
    assign issue = fetch_en & ~br_taken & ~pc_rst & (occ < 2'd2);

    assign mem_addr   = fetch_pc_q[MEM_AW+1:2];
    assign Inst_out   = out_inst_q;
    assign PC_out     = out_pc_q;
    assign inst_valid = out_valid_q;
    assign align_err  = align_err_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        out_valid_d   = out_valid_q;
        out_inst_d    = out_inst_q;
        out_pc_d      = out_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_inst_d   = skid_inst_q;
        skid_pc_d     = skid_pc_q;
        align_err_d   = 1'b0;

        if (br_taken) begin
            fetch_pc_d   = {br_target[ADDR_W-1:2], 2'b00};
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            align_err_d  = |br_target[1:0];
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
            end
            if (inflight_q) begin
                if (!out_valid_q || (pop && !skid_valid_q)) begin
                    out_valid_d = 1'b1;
                    out_inst_d  = Inst_in;
                    out_pc_d    = inflight_pc_q;
                end else if (pop) begin
                    out_inst_d   = skid_inst_q;
                    out_pc_d     = skid_pc_q;
                    skid_valid_d = 1'b1;
                    skid_inst_d  = Inst_in;
                    skid_pc_d    = inflight_pc_q;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_inst_d  = Inst_in;
                    skid_pc_d    = inflight_pc_q;
                end
            end else if (pop) begin
                if (skid_valid_q) begin
                    out_inst_d   = skid_inst_q;
                    out_pc_d     = skid_pc_q;
                    skid_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (pc_rst) begin
            fetch_pc_q    <= RESET_VEC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            out_valid_q   <= 1'b0;
            out_inst_q    <= '0;
            out_pc_q      <= '0;
            skid_valid_q  <= 1'b0;
            skid_inst_q   <= '0;
            skid_pc_q     <= '0;
            align_err_q   <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            out_valid_q   <= out_valid_d;
            out_inst_q    <= out_inst_d;
            out_pc_q      <= out_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_inst_q   <= skid_inst_d;
            skid_pc_q     <= skid_pc_d;
            align_err_q   <= align_err_d;
        end
    end

    // A response landing while both buffer entries are held would be lost.
    skid_no_overflow: assert property (@(posedge clk1) disable iff (pc_rst)
        !(inflight_q && out_valid_q && skid_valid_q && !pop && !br_taken));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: queue-based delivery model checked every cycle, plus directed
// scenarios (stream, hold, back-pressure, redirect, misaligned redirect, wrap, mid-stream reset).
module tb_ifu_prefetch;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 12;
    localparam int unsigned MW = 10;

    logic          clk1 = 1'b0;
    logic          pc_rst, fetch_en, br_taken, dec_ready;
    logic [AW-1:0] br_target;
    logic [MW-1:0] mem_addr;
    logic [DW-1:0] Inst_in, Inst_out;
    logic [AW-1:0] PC_out;
    logic          inst_valid, align_err;

    int total = 0;
    int bad   = 0;

    ifu_prefetch #(.DATA_W(DW), .ADDR_W(AW), .MEM_AW(MW), .RESET_VEC('0)) dut (
        .clk1(clk1), .pc_rst(pc_rst), .fetch_en(fetch_en), .br_taken(br_taken),
        .br_target(br_target), .mem_addr(mem_addr), .Inst_in(Inst_in), .Inst_out(Inst_out),
        .PC_out(PC_out), .inst_valid(inst_valid), .dec_ready(dec_ready), .align_err(align_err)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [31:0] word_of(input int idx);
        if (idx == 0) return 32'd102;
        if (idx == 1) return 32'd64;
        if (idx == 2) return 32'd3;
        return 32'hA500_0000 | 32'(idx);
    endfunction

    logic [DW-1:0] ram [1024];
    initial for (int i = 0; i < 1024; i++) ram[i] = word_of(i);
    always @(posedge clk1) Inst_in <= ram[mem_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words headed for decode as a queue of PCs (front is on the output), one fetch slot.
    logic [AW-1:0] mq[$];
    logic          m_inf = 1'b0;
    logic [AW-1:0] m_inf_pc, m_fpc;
    logic          m_align = 1'b0;
    logic          m_zero = 1'b0;
    logic          started = 1'b0;
    int            cyc = 0;

    always @(posedge clk1) begin
        int occ;
        bit pop, issue;
        cyc++;
        if (pc_rst) begin
            mq.delete();
            m_inf   = 1'b0;
            m_fpc   = '0;
            m_align = 1'b0;
            m_zero  = 1'b1;
            started = 1'b1;
        end else if (started) begin
            pop   = (mq.size() > 0) && dec_ready;
            occ   = mq.size() + int'(m_inf) - int'(pop);
            issue = fetch_en && !br_taken && (occ < 2);
            if (pop) void'(mq.pop_front());
            if (br_taken) begin
                mq.delete();
                m_inf   = 1'b0;
                m_fpc   = {br_target[AW-1:2], 2'b00};
                m_align = |br_target[1:0];
            end else begin
                if (m_inf) begin
                    mq.push_back(m_inf_pc);
                    m_zero = 1'b0;
                end
                m_align = 1'b0;
                if (issue) begin
                    m_inf    = 1'b1;
                    m_inf_pc = m_fpc;
                    m_fpc    = m_fpc + 12'd4;
                end else begin
                    m_inf = 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] inst;
        int            cyc;
    } deliv_t;
    deliv_t dlog[$];
    int align_cnt = 0;

    always @(negedge clk1) begin
        if (started) begin
            chk("mem_addr", 64'(mem_addr), 64'(m_fpc[AW-1:2]));
            chk("inst_valid", 64'(inst_valid), 64'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("pc_out", 64'(PC_out), 64'(mq[0]));
                chk("inst_out", 64'(Inst_out), 64'(word_of(int'(mq[0][AW-1:2]))));
            end else if (m_zero) begin
                chk("pc_out_zero", 64'(PC_out), 64'd0);
                chk("inst_out_zero", 64'(Inst_out), 64'd0);
            end
            chk("align_err", 64'(align_err), 64'(m_align));
            if (align_err) align_cnt++;
            if (!pc_rst && inst_valid && dec_ready)
                dlog.push_back('{pc: PC_out, inst: Inst_out, cyc: cyc});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk1);
            #1;
        end
    endtask

    task automatic chk_log(input string name, input int idx, input logic [AW-1:0] pc,
                           input logic [DW-1:0] inst);
        if (dlog.size() > idx) begin
            chk({name, "_pc"}, 64'(dlog[idx].pc), 64'(pc));
            chk({name, "_inst"}, 64'(dlog[idx].inst), 64'(inst));
        end else begin
            chk({name, "_present"}, 64'(dlog.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        pc_rst = 1'b1; fetch_en = 1'b0; br_taken = 1'b0; br_target = '0; dec_ready = 1'b1;
        tick(2);
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_pc", 64'(PC_out), 64'd0);
        chk("rst_inst", 64'(Inst_out), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);

        // Stream from reset
        pc_rst = 1'b0; fetch_en = 1'b1; dlog.delete();
        tick(1);
        chk("lat_issue_valid", 64'(inst_valid), 64'd0);
        tick(1);
        chk("lat_first_valid", 64'(inst_valid), 64'd1);
        chk("lat_first_inst", 64'(Inst_out), 64'd102);
        tick(4);
        chk_log("stream0", 0, 12'h000, 32'd102);
        chk_log("stream1", 1, 12'h004, 32'd64);
        chk_log("stream2", 2, 12'h008, 32'd3);
        if (dlog.size() > 2) begin
            chk("stream_consec1", 64'(dlog[1].cyc - dlog[0].cyc), 64'd1);
            chk("stream_consec2", 64'(dlog[2].cyc - dlog[1].cyc), 64'd1);
        end

        // Reset with a word in flight
        pc_rst = 1'b1;
        tick(1);
        chk("midrst_valid", 64'(inst_valid), 64'd0);
        chk("midrst_pc", 64'(PC_out), 64'd0);
        chk("midrst_inst", 64'(Inst_out), 64'd0);
        chk("midrst_addr", 64'(mem_addr), 64'd0);

        // Hold: issue only word0
        pc_rst = 1'b0; fetch_en = 1'b1; dlog.delete();
        tick(1);
        fetch_en = 1'b0;
        tick(1);
        chk("hold_w0_valid", 64'(inst_valid), 64'd1);
        chk("hold_w0_inst", 64'(Inst_out), 64'd102);
        tick(1);
        chk("hold_empty", 64'(inst_valid), 64'd0);
        tick(3);
        chk("hold_still_empty", 64'(inst_valid), 64'd0);
        chk("hold_addr", 64'(mem_addr), 64'd1);
        chk("hold_count", 64'(dlog.size()), 64'd1);
        fetch_en = 1'b1;
        tick(2);
        chk("hold_resume_pc", 64'(PC_out), 64'h4);
        chk("hold_resume_inst", 64'(Inst_out), 64'd64);

        // Back-pressure
        pc_rst = 1'b1;
        tick(1);
        pc_rst = 1'b0; fetch_en = 1'b1; dec_ready = 1'b0; dlog.delete();
        tick(7);
        chk("bp_pc", 64'(PC_out), 64'd0);
        chk("bp_inst", 64'(Inst_out), 64'd102);
        chk("bp_addr", 64'(mem_addr), 64'd2);
        chk("bp_none", 64'(dlog.size()), 64'd0);
        dec_ready = 1'b1;
        tick(6);
        chk_log("bp0", 0, 12'h000, 32'd102);
        chk_log("bp1", 1, 12'h004, 32'd64);
        chk_log("bp2", 2, 12'h008, 32'd3);
        chk_log("bp3", 3, 12'h00C, word_of(3));

        // Redirect to 8 with words 1 and 2 outstanding
        pc_rst = 1'b1;
        tick(1);
        pc_rst = 1'b0; fetch_en = 1'b1; dec_ready = 1'b1;
        tick(3);
        chk("br_pre_pc", 64'(PC_out), 64'h4);
        dec_ready = 1'b0; br_taken = 1'b1; br_target = 12'h008; align_cnt = 0;
        tick(1);
        br_taken = 1'b0; dec_ready = 1'b1; dlog.delete();
        chk("br_flush_valid", 64'(inst_valid), 64'd0);
        tick(1);
        chk("br_issue_valid", 64'(inst_valid), 64'd0);
        tick(1);
        chk("br_first_pc", 64'(PC_out), 64'h8);
        chk("br_first_inst", 64'(Inst_out), 64'd3);
        tick(2);
        chk_log("br0", 0, 12'h008, 32'd3);
        chk("br_align_cnt", 64'(align_cnt), 64'd0);

        // Misaligned redirect
        br_taken = 1'b1; br_target = 12'h006; align_cnt = 0;
        tick(1);
        br_taken = 1'b0; dlog.delete();
        chk("mis_align_hi", 64'(align_err), 64'd1);
        tick(1);
        chk("mis_align_lo", 64'(align_err), 64'd0);
        tick(3);
        chk("mis_align_cnt", 64'(align_cnt), 64'd1);
        chk_log("mis0", 0, 12'h004, 32'd64);

        // Wrap at the top of the 12-bit PC space
        br_taken = 1'b1; br_target = 12'hFFC;
        tick(1);
        br_taken = 1'b0; dlog.delete();
        tick(5);
        chk_log("wrap0", 0, 12'hFFC, word_of(1023));
        chk_log("wrap1", 1, 12'h000, 32'd102);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
